cfo_rot: RTL
============

CFO_ROT -- requirements
Module: cfo_rot

Interface
REQ-001 Parameter DW, default 16: I/Q sample width, signed two's complement.
REQ-002 Parameter PW, default 32: phase accumulator and frequency word width.
REQ-003 Parameter LW, default 10: phase bits used to address the sin/cos table (2^LW entries per full turn).
REQ-004 clk  in  1: sole clock, all state on rising edge.
REQ-005 reset_n  in  1: asynchronous active-low reset.
REQ-006 in_valid  in  1: i_in/q_in carry a sample this cycle.
REQ-007 i_in, q_in  in  DW: input sample.
REQ-008 freq_word  in  PW: signed phase increment per accepted sample (2^PW = one turn).
REQ-009 freq_load  in  1: capture freq_word into freq_reg.
REQ-010 phase_clr  in  1: force the phase for the current/next sample to zero.
REQ-011 bypass  in  1: pass samples unrotated.
REQ-012 out_valid  out  1: i_out/q_out valid.
REQ-013 i_out, q_out  out  DW: rotated sample.
REQ-014 phase_out  out  PW: current accumulator value.
REQ-015 sat_cnt  out  16: count of saturated output samples.

Function
REQ-016 Accumulator advances by freq_reg only on cycles with in_valid=1; no advance on idle cycles.
REQ-017 Each sample is rotated by the accumulator value held before that cycle's update (first sample after reset uses phase 0).
REQ-018 freq_load=1 updates freq_reg at the clock edge; the new value first applies to the accumulator update of the next cycle, never to the same cycle.
REQ-019 phase_clr=1 with in_valid=1: sample uses phase 0, accumulator becomes freq_reg; phase_clr=1 with in_valid=0: accumulator becomes 0.
REQ-020 Table holds round((2^(DW-1)-1)*cos/sin(2*pi*k/2^LW)), addressed by accumulator bits [PW-1:PW-LW], truncated, no interpolation.
REQ-021 i_out = I*cos - Q*sin, q_out = I*sin + Q*cos, full-precision products and sum (2*DW+1 bits).
REQ-022 Result scaled by adding 2^(DW-2) then arithmetic shift right by DW-1 (round half up).
REQ-023 Scaled result saturates to [-2^(DW-1), 2^(DW-1)-1] per component.
REQ-024 Pipeline latency fixed at 3 cycles: stage 1 table lookup and input register, stage 2 multiply, stage 3 sum/round/saturate; out_valid = in_valid delayed 3 cycles.
REQ-025 Pipeline has no stall; every in_valid produces exactly one out_valid, back-to-back supported at full rate.
REQ-026 bypass=1 (sampled with in_valid): output equals input delayed 3 cycles; accumulator still advances; no saturation possible.
REQ-027 sat_cnt increments by 1 per output sample where either component saturated; holds at 0xFFFF.
REQ-028 Accumulator wraps modulo 2^PW; negative freq_word rotates clockwise.
REQ-029 i_out/q_out hold last value when out_valid=0.

Reset
REQ-030 reset_n=0 clears accumulator, freq_reg, sat_cnt, all pipeline valids, i_out, q_out, phase_out to 0 immediately, independent of clk.
REQ-031 Samples in flight at reset assertion are discarded; no out_valid until 3 cycles after the first post-reset in_valid.

Verification
REQ-032 freq_reg=0, in (1000,0) continuous -> out (1000,0) every cycle from cycle 3, sat_cnt=0.
REQ-033 freq_word=0x40000000 loaded, in (1000,0) x4 -> out (1000,0),(0,1000),(-1000,0),(0,-1000); phase_out back to 0.
REQ-034 Phase fixed at 45 deg (accumulator 0x20000000), in (32767,32767) -> out (0,32767), sat_cnt=1.
REQ-035 in_valid gaps of 5 idle cycles between quarter-turn samples -> same output sequence as REQ-033, phase_out unchanged during gaps.
REQ-036 phase_clr with in_valid mid-stream -> that sample output unrotated, following sample rotated by exactly one freq_reg step.
REQ-037 reset_n pulsed low with 2 samples in flight -> no out_valid for those samples, all outputs 0, next sample uses phase 0.

Source files
------------

// File: rtl/cfo_rot.sv
// rtl/cfo_rot.sv - carrier frequency offset rotator
// Table-driven complex rotator with a phase accumulator, 3-stage pipeline and saturation counter.
module cfo_rot #(
   parameter int DW = 16,
   parameter int PW = 32,
   parameter int LW = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] i_in,
   input  logic signed [DW-1:0] q_in,
   input  logic [PW-1:0]        freq_word,
   input  logic                 freq_load,
   input  logic                 phase_clr,
   input  logic                 bypass,
   output logic                 out_valid,
   output logic signed [DW-1:0] i_out,
   output logic signed [DW-1:0] q_out,
   output logic [PW-1:0]        phase_out,
   output logic [15:0]          sat_cnt
);

   localparam int  TN   = 1 << LW;
   localparam int  PWID = 2 * DW;
   localparam int  SWID = 2 * DW + 1;
   localparam real PI   = 3.14159265358979323846;
   localparam real AMP  = real'((1 << (DW - 1)) - 1);

   localparam logic signed [SWID-1:0] RND  = SWID'(1 << (DW - 2));
   localparam logic signed [SWID-1:0] MAXV = SWID'((1 << (DW - 1)) - 1);
   localparam logic signed [SWID-1:0] MINV = ~MAXV;

   logic signed [DW-1:0] cos_tab [TN];
   logic signed [DW-1:0] sin_tab [TN];

   // Tables are constants evaluated at elaboration, rounded half away from zero.
   for (genvar k = 0; k < TN; k++) begin : g_tab
      localparam real ANG = 2.0 * PI * real'(k) / real'(TN);
      localparam real CV  = AMP * $cos(ANG);
      localparam real SV  = AMP * $sin(ANG);
      localparam int  CI  = (CV >= 0.0) ? $rtoi(CV + 0.5) : -$rtoi(0.5 - CV);
      localparam int  SI  = (SV >= 0.0) ? $rtoi(SV + 0.5) : -$rtoi(0.5 - SV);
      assign cos_tab[k] = CI[DW-1:0];
      assign sin_tab[k] = SI[DW-1:0];
   end

   logic [PW-1:0]          acc_q, acc_d;
   logic [PW-1:0]          freq_q, freq_d;
   logic                   s1_vld_q, s1_vld_d;
   logic                   s1_byp_q, s1_byp_d;
   logic signed [DW-1:0]   s1_i_q, s1_i_d;
   logic signed [DW-1:0]   s1_q_q, s1_q_d;
   logic signed [DW-1:0]   s1_cos_q, s1_cos_d;
   logic signed [DW-1:0]   s1_sin_q, s1_sin_d;
   logic                   s2_vld_q, s2_vld_d;
   logic                   s2_byp_q, s2_byp_d;
   logic signed [DW-1:0]   s2_i_q, s2_i_d;
   logic signed [DW-1:0]   s2_q_q, s2_q_d;
   logic signed [PWID-1:0] s2_ic_q, s2_ic_d;
   logic signed [PWID-1:0] s2_qs_q, s2_qs_d;
   logic signed [PWID-1:0] s2_is_q, s2_is_d;
   logic signed [PWID-1:0] s2_qc_q, s2_qc_d;
   logic                   out_vld_q, out_vld_d;
   logic signed [DW-1:0]   i_out_q, i_out_d;
   logic signed [DW-1:0]   q_out_q, q_out_d;
   logic [15:0]            sat_cnt_q, sat_cnt_d;

   logic [PW-1:0]          ph_use;
   logic [LW-1:0]          tab_idx;
   logic signed [SWID-1:0] sum_i, sum_q, scl_i, scl_q;
   logic                   sat_i, sat_q;
   logic signed [DW-1:0]   res_i, res_q;

   // Stage 1: phase selection, accumulator update, table lookup.
   always_comb begin
      ph_use   = phase_clr ? '0 : acc_q;
      tab_idx  = ph_use[PW-1:PW-LW];
      acc_d    = acc_q;
      if (in_valid) begin
         acc_d = ph_use + freq_q;
      end else if (phase_clr) begin
         acc_d = '0;
      end
      freq_d   = freq_load ? freq_word : freq_q;
      s1_vld_d = in_valid;
      s1_byp_d = bypass;
      s1_i_d   = i_in;
      s1_q_d   = q_in;
      s1_cos_d = cos_tab[tab_idx];
      s1_sin_d = sin_tab[tab_idx];
   end

   // Stage 2: full-precision products.
   always_comb begin
      s2_vld_d = s1_vld_q;
      s2_byp_d = s1_byp_q;
      s2_i_d   = s1_i_q;
      s2_q_d   = s1_q_q;
      s2_ic_d  = PWID'(s1_i_q) * PWID'(s1_cos_q);
      s2_qs_d  = PWID'(s1_q_q) * PWID'(s1_sin_q);
      s2_is_d  = PWID'(s1_i_q) * PWID'(s1_sin_q);
      s2_qc_d  = PWID'(s1_q_q) * PWID'(s1_cos_q);
   end

   // Stage 3: sum, round half up, saturate; outputs hold between valid samples.
   always_comb begin
      sum_i = SWID'(s2_ic_q) - SWID'(s2_qs_q);
      sum_q = SWID'(s2_is_q) + SWID'(s2_qc_q);
      scl_i = (sum_i + RND) >>> (DW - 1);
      scl_q = (sum_q + RND) >>> (DW - 1);
      sat_i = 1'b0;
      sat_q = 1'b0;
      res_i = scl_i[DW-1:0];
      res_q = scl_q[DW-1:0];
      if (s2_byp_q) begin
         res_i = s2_i_q;
         res_q = s2_q_q;
      end else begin
         if (scl_i > MAXV) begin
            sat_i = 1'b1;
            res_i = MAXV[DW-1:0];
         end else if (scl_i < MINV) begin
            sat_i = 1'b1;
            res_i = MINV[DW-1:0];
         end
         if (scl_q > MAXV) begin
            sat_q = 1'b1;
            res_q = MAXV[DW-1:0];
         end else if (scl_q < MINV) begin
            sat_q = 1'b1;
            res_q = MINV[DW-1:0];
         end
      end
      out_vld_d = s2_vld_q;
      i_out_d   = s2_vld_q ? res_i : i_out_q;
      q_out_d   = s2_vld_q ? res_q : q_out_q;
      sat_cnt_d = sat_cnt_q;
      if (s2_vld_q && (sat_i || sat_q) && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_d = sat_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q     <= '0;
         freq_q    <= '0;
         s1_vld_q  <= 1'b0;
         s1_byp_q  <= 1'b0;
         s1_i_q    <= '0;
         s1_q_q    <= '0;
         s1_cos_q  <= '0;
         s1_sin_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_byp_q  <= 1'b0;
         s2_i_q    <= '0;
         s2_q_q    <= '0;
         s2_ic_q   <= '0;
         s2_qs_q   <= '0;
         s2_is_q   <= '0;
         s2_qc_q   <= '0;
         out_vld_q <= 1'b0;
         i_out_q   <= '0;
         q_out_q   <= '0;
         sat_cnt_q <= '0;
      end else begin
         acc_q     <= acc_d;
         freq_q    <= freq_d;
         s1_vld_q  <= s1_vld_d;
         s1_byp_q  <= s1_byp_d;
         s1_i_q    <= s1_i_d;
         s1_q_q    <= s1_q_d;
         s1_cos_q  <= s1_cos_d;
         s1_sin_q  <= s1_sin_d;
         s2_vld_q  <= s2_vld_d;
         s2_byp_q  <= s2_byp_d;
         s2_i_q    <= s2_i_d;
         s2_q_q    <= s2_q_d;
         s2_ic_q   <= s2_ic_d;
         s2_qs_q   <= s2_qs_d;
         s2_is_q   <= s2_is_d;
         s2_qc_q   <= s2_qc_d;
         out_vld_q <= out_vld_d;
         i_out_q   <= i_out_d;
         q_out_q   <= q_out_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign out_valid = out_vld_q;
   assign i_out     = i_out_q;
   assign q_out     = q_out_q;
   assign phase_out = acc_q;
   assign sat_cnt   = sat_cnt_q;

endmodule
